intersection_sequencer: RTL and testbench

- Cycle-accurate phase controller for a two-approach intersection: north-south (NS) and east-west (EW).
- Drives one red/yellow/green lamp triple per approach.
- Latches vehicle-detector requests and rests in green when the cross approach has no demand.
- Sits above the single-head lamp logic and guarantees that conflicting greens never occur.

---
 rtl/intersection_pkg.sv | 41 ++++
 rtl/phase_timer.sv | 27 ++
 rtl/intersection_sequencer.sv | 140 ++++++++++++++
 tb/tb_intersection_sequencer.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/intersection_pkg.sv
// Shared types and constants for the two-approach intersection sequencer.
// Phase codes double as the external phase status encoding.
package intersection_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        NS_G  = 3'd1,
        NS_Y  = 3'd2,
        AR_NS = 3'd3,
        EW_G  = 3'd4,
        EW_Y  = 3'd5,
        AR_EW = 3'd6
    } phase_t;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    localparam int DEF_GREEN_T  = 70;
    localparam int DEF_YELLOW_T = 5;
    localparam int DEF_ALLRED_T = 2;
    localparam int DEF_WALK_T   = 20;
    localparam int DEF_CNT_W    = 8;

    function automatic logic [2:0] ns_lamp(input phase_t p);
        logic [2:0] l;
        l = LAMP_RED;
        if (p == NS_G) l = LAMP_GRN;
        if (p == NS_Y) l = LAMP_YEL;
        return l;
    endfunction

    function automatic logic [2:0] ew_lamp(input phase_t p);
        logic [2:0] l;
        l = LAMP_RED;
        if (p == EW_G) l = LAMP_GRN;
        if (p == EW_Y) l = LAMP_YEL;
        return l;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Per-phase cycle counter: clears on phase entry, counts up and
// holds at the selected terminal count so a resting green stays expired.
module phase_timer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic [CNT_W-1:0] tc,
    output logic             expire
);

    logic [CNT_W-1:0] cnt;

    assign expire = (cnt == tc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (!expire) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/intersection_sequencer.sv
// Two-approach traffic phase controller with demand-latched rest in green.
// Optional pedestrian walk extension of all-red enabled by PED_WALK_EN.
module intersection_sequencer
    import intersection_pkg::*;
#(
    parameter int GREEN_T  = DEF_GREEN_T,
    parameter int YELLOW_T = DEF_YELLOW_T,
    parameter int ALLRED_T = DEF_ALLRED_T,
`ifdef PED_WALK_EN
    parameter int WALK_T   = DEF_WALK_T,
`endif
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       ns_req,
    input  logic       ew_req,
`ifdef PED_WALK_EN
    input  logic       ped_req,
    output logic       walk,
`endif
    output logic       ns_green,
    output logic       ns_yellow,
    output logic       ns_red,
    output logic       ew_green,
    output logic       ew_yellow,
    output logic       ew_red,
    output logic [2:0] phase
);

    localparam logic [CNT_W-1:0] TC_G = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] TC_Y = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] TC_A = CNT_W'(ALLRED_T - 1);
`ifdef PED_WALK_EN
    localparam logic [CNT_W-1:0] TC_W = CNT_W'(WALK_T - 1);
`endif

    phase_t           state;
    phase_t           nxt;
    logic             pend_ns;
    logic             pend_ew;
    logic             dem_ns;
    logic             dem_ew;
    logic             enter;
    logic             expire;
    logic [CNT_W-1:0] tc;
    logic [2:0]       ns_l;
    logic [2:0]       ew_l;
`ifdef PED_WALK_EN
    logic             pend_ped;
    logic             walk_q;
    logic             enter_ar;
`endif

    // A live request counts as demand immediately, not one cycle late
    assign dem_ns = pend_ns | ns_req;
    assign dem_ew = pend_ew | ew_req;
    assign enter  = (nxt != state);

    always_comb begin
        tc = '0;
        unique case (state)
            NS_G, EW_G:   tc = TC_G;
            NS_Y, EW_Y:   tc = TC_Y;
`ifdef PED_WALK_EN
            AR_NS, AR_EW: tc = walk_q ? TC_W : TC_A;
`else
            AR_NS, AR_EW: tc = TC_A;
`endif
            default:      tc = '0;
        endcase
    end

    always_comb begin
        nxt = state;
        unique case (state)
            IDLE:  if (enable) nxt = NS_G;
            NS_G:  if (!enable || (expire && dem_ew)) nxt = NS_Y;
            NS_Y:  if (expire) nxt = AR_NS;
            AR_NS: if (expire) nxt = enable ? EW_G : IDLE;
            EW_G:  if (!enable || (expire && dem_ns)) nxt = EW_Y;
            EW_Y:  if (expire) nxt = AR_EW;
            AR_EW: if (expire) nxt = enable ? NS_G : IDLE;
            default: nxt = IDLE;
        endcase
    end

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (enter),
        .tc     (tc),
        .expire (expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pend_ns <= 1'b0;
            pend_ew <= 1'b0;
            ns_l    <= LAMP_RED;
            ew_l    <= LAMP_RED;
        end else begin
            state <= nxt;
            ns_l  <= ns_lamp(nxt);
            ew_l  <= ew_lamp(nxt);
            // Entering the green serves the request, even one arriving now
            if (enter && nxt == NS_G) pend_ns <= 1'b0;
            else if (state != NS_G && ns_req) pend_ns <= 1'b1;
            if (enter && nxt == EW_G) pend_ew <= 1'b0;
            else if (state != EW_G && ew_req) pend_ew <= 1'b1;
        end
    end

`ifdef PED_WALK_EN
    assign enter_ar = enter && (nxt == AR_NS || nxt == AR_EW);
    assign walk     = walk_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_ped <= 1'b0;
            walk_q   <= 1'b0;
        end else if (enter_ar) begin
            pend_ped <= 1'b0;
            walk_q   <= pend_ped | ped_req;
        end else begin
            pend_ped <= pend_ped | ped_req;
            if (enter) walk_q <= 1'b0;
        end
    end
`endif

    assign {ns_red, ns_yellow, ns_green} = ns_l;
    assign {ew_red, ew_yellow, ew_green} = ew_l;
    assign phase = state;

endmodule

// File: tb/tb_intersection_sequencer.sv
// Directed and random checks of intersection_sequencer against a
// timeline model of the phase rules.
module tb_intersection_sequencer;

    localparam int G = 4;
    localparam int Y = 2;
    localparam int A = 1;
`ifdef PED_WALK_EN
    localparam int W = 3;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic enable = 1'b0;
    logic ns_req = 1'b0;
    logic ew_req = 1'b0;
    logic ns_green, ns_yellow, ns_red;
    logic ew_green, ew_yellow, ew_red;
    logic [2:0] phase;
`ifdef PED_WALK_EN
    logic ped_req = 1'b0;
    logic walk;
`endif

    int n_chk = 0;
    int n_fail = 0;

    int m_ph;
    int m_age;
    bit m_pns;
    bit m_pew;
`ifdef PED_WALK_EN
    bit m_ped;
    bit m_walk;
`endif

    intersection_sequencer #(
        .GREEN_T  (G),
        .YELLOW_T (Y),
        .ALLRED_T (A),
`ifdef PED_WALK_EN
        .WALK_T   (W),
`endif
        .CNT_W    (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .ns_req    (ns_req),
        .ew_req    (ew_req),
`ifdef PED_WALK_EN
        .ped_req   (ped_req),
        .walk      (walk),
`endif
        .ns_green  (ns_green),
        .ns_yellow (ns_yellow),
        .ns_red    (ns_red),
        .ew_green  (ew_green),
        .ew_yellow (ew_yellow),
        .ew_red    (ew_red),
        .phase     (phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int dur(input int ph);
        int d;
        d = 1;
        if (ph == 1 || ph == 4) d = G;
        if (ph == 2 || ph == 5) d = Y;
`ifdef PED_WALK_EN
        if (ph == 3 || ph == 6) d = m_walk ? W : A;
`else
        if (ph == 3 || ph == 6) d = A;
`endif
        return d;
    endfunction

    function automatic logic [2:0] exp_lamp(input int ph, input int g);
        logic [2:0] l;
        l = 3'b100;
        if (ph == g) l = 3'b001;
        if (ph == g + 1) l = 3'b010;
        return l;
    endfunction

    task automatic model_reset();
        m_ph = 0;
        m_age = 0;
        m_pns = 0;
        m_pew = 0;
`ifdef PED_WALK_EN
        m_ped = 0;
        m_walk = 0;
`endif
    endtask

    task automatic model_step();
        int nx;
        bit done;
        bit ent;
        done = (m_age >= dur(m_ph) - 1);
        nx = m_ph;
        case (m_ph)
            0: if (enable) nx = 1;
            1: if (!enable || (done && (m_pew || ew_req))) nx = 2;
            2: if (done) nx = 3;
            3: if (done) nx = enable ? 4 : 0;
            4: if (!enable || (done && (m_pns || ns_req))) nx = 5;
            5: if (done) nx = 6;
            6: if (done) nx = enable ? 1 : 0;
            default: nx = 0;
        endcase
        ent = (nx != m_ph);
        if (ent && nx == 4) m_pew = 0;
        else if (m_ph != 4 && ew_req) m_pew = 1;
        if (ent && nx == 1) m_pns = 0;
        else if (m_ph != 1 && ns_req) m_pns = 1;
`ifdef PED_WALK_EN
        if (ent && (nx == 3 || nx == 6)) begin
            m_walk = m_ped || ped_req;
            m_ped = 0;
        end else begin
            if (ent) m_walk = 0;
            m_ped = m_ped || ped_req;
        end
`endif
        m_age = ent ? 0 : m_age + 1;
        m_ph = nx;
    endtask

    task automatic check_all();
        check("phase", phase, m_ph);
        check("ns_lamps", {ns_red, ns_yellow, ns_green}, exp_lamp(m_ph, 1));
        check("ew_lamps", {ew_red, ew_yellow, ew_green}, exp_lamp(m_ph, 4));
        check("no_conflict", ns_green & ew_green, 1'b0);
        check("some_red", ns_red | ew_red, 1'b1);
`ifdef PED_WALK_EN
        check("walk", walk, m_walk);
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #2;
        check_all();
        rst_n = 1'b1;
    endtask

    int rec[28];
    int exp1[14] = '{1, 1, 1, 1, 2, 2, 3, 4, 4, 4, 4, 5, 5, 6};
    int len;

    initial begin
        model_reset();
        #12;
        check_all();
        check("reset_phase", phase, 0);
        rst_n = 1'b1;

        // Both approaches demanding: full cycle repeats
        enable = 1'b1;
        ns_req = 1'b1;
        ew_req = 1'b1;
        for (int i = 0; i < 28; i++) begin
            tick();
            rec[i] = int'(phase);
        end
        for (int i = 0; i < 28; i++) check("s1_seq", rec[i], exp1[i % 14]);

        enable = 1'b0;
        ns_req = 1'b0;
        ew_req = 1'b0;
        len = 0;
        while (m_ph != 0 && len < 30) begin
            tick();
            len++;
        end
        check("drain_idle", phase, 0);

        // No demand: rest in NS green, then a late EW pulse
        @(negedge clk);
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        check("s2_rest", phase, 1);
        ew_req = 1'b1;
        tick();
        ew_req = 1'b0;
        check("s2_to_y", phase, 2);
        for (int i = 0; i < 3; i++) tick();
        check("s2_ewg", phase, 4);

        // Enable dropped early in NS green
        @(negedge clk);
        do_reset();
        tick();
        tick();
        enable = 1'b0;
        tick();
        check("s3_y_now", phase, 2);
        tick();
        check("s3_y_hold", phase, 2);
        tick();
        check("s3_ar", phase, 3);
        tick();
        check("s3_idle", phase, 0);
        check("s3_reds", {ns_red, ew_red}, 2'b11);
        enable = 1'b1;
        tick();
        check("s3_restart", phase, 1);

        // Request coincident with entry into EW green is consumed
        for (int i = 0; i < 3; i++) tick();
        ew_req = 1'b1;
        tick();
        ew_req = 1'b0;
        tick();
        tick();
        check("s4_ar", phase, 3);
        ew_req = 1'b1;
        tick();
        ew_req = 1'b0;
        check("s4_ewg", phase, 4);
        check("s4_pend_ew", dut.pend_ew, 1'b0);
        ns_req = 1'b1;
        len = 1;
        tick();
        ns_req = 1'b0;
        check("s4_pend_ns", dut.pend_ns, 1'b1);
        while (m_ph == 4 && len < 10) begin
            len++;
            tick();
        end
        check("s4_ewg_len", len, 4);
        check("s4_ewy", phase, 5);

        // Asynchronous reset between edges in EW yellow
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        check("s5_phase", phase, 0);
        check("s5_lamps", {ns_red, ns_yellow, ns_green, ew_red, ew_yellow,
                           ew_green}, 6'b100100);
        #2;
        rst_n = 1'b1;

`ifdef PED_WALK_EN
        @(negedge clk);
        do_reset();
        enable = 1'b1;
        tick();
        ped_req = 1'b1;
        tick();
        ped_req = 1'b0;
        ew_req = 1'b1;
        tick();
        ew_req = 1'b0;
        len = 0;
        while (m_ph != 3 && len < 20) begin
            tick();
            len++;
        end
        check("s6_ar", phase, 3);
        len = 0;
        while (m_ph == 3 && len < 10) begin
            check("s6_walk_on", walk, 1'b1);
            len++;
            tick();
        end
        check("s6_ar_len", len, W);
        check("s6_ewg", phase, 4);
        check("s6_walk_off", walk, 1'b0);
`endif

        // Random traffic against the model
        @(negedge clk);
        do_reset();
        for (int i = 0; i < 600; i++) begin
            enable = ($urandom_range(0, 15) != 0);
            ns_req = ($urandom_range(0, 5) == 0);
            ew_req = ($urandom_range(0, 5) == 0);
`ifdef PED_WALK_EN
            ped_req = ($urandom_range(0, 9) == 0);
`endif
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
